multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style main control FSM for the multi-cycle RV32I core.
- Sits directly upstream of the immediate extender and the datapath: decodes the instruction-register fields and drives imm_src for the extender, plus every mux select and write enable.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq/bne, jal, lui, auipc.

Parameters:
- STATE_W, 4, width of the state register and the debug state port.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address: 0=PC, 1=result.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register + old_pc enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  00=alu_out reg, 01=mem data reg, 10=alu_result.
- alu_src_a  out  2  00=PC, 01=old_pc, 10=rs1 reg, 11=zero.
- alu_src_b  out  2  00=rs2 reg, 01=imm_ext, 10=const 4.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- imm_src  out  3  to extender.
- state  out  STATE_W  debug copy of the state register.
- illegal  out  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset is synchronous, active-high. While rst=1, pc_write, ir_write, mem_write and reg_write are forced to 0. The next rising edge loads FETCH.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BRANCH=10, LUI=11, ERROR=12.
- Outputs decode only from state; imm_src and alu_control also use op/funct. Any select not listed for a state is 0.
- imm_src is combinational from op in every state:
  - lw/I-type: 000.
  - sw: 001.
  - branch: 010.
  - jal: 011.
  - lui/auipc: 100.
  - any other op: 000.
- FETCH: adr_src=0, ir_write=1, a=00, b=10, add, result_src=10, pc_write=1. Next state: DECODE.
- DECODE: a=01, b=01, add (branch/jal/auipc target captured in alu_out). Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECUTER.
  - 0010011 -> EXECUTEI.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - 0110111 -> LUI.
  - 0010111 -> ALUWB.
  - other -> FETCH.
- MEMADR: a=10, b=01, add. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Next: FETCH.
- EXECUTER: a=10, b=00, ALU op from funct3. Next: ALUWB.
  - funct3 mapping: 000 add/sub (sub iff funct7b5=1), 111 and, 110 or, 100 xor, 010 slt, 001 sll, 101 srl.
- EXECUTEI: a=10, b=01. Same funct3 mapping, except 000 is always add (funct7b5 ignored). Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- JAL: a=01, b=10, add, result_src=00, pc_write=1. PC takes the target held in alu_out; alu_result = old_pc+4. Next: ALUWB.
- LUI: a=11, b=01, add. Next: ALUWB.
- BRANCH: a=10, b=00, sub, result_src=00.
  - pc_write = zero when funct3=000; pc_write = ~zero when funct3=001; pc_write = 0 otherwise.
  - Next: FETCH.
- Cycles per instruction: lw 5, sw/R/I/jal/lui 4, branch/auipc 3.
- rst asserted mid-instruction aborts the instruction; no write enable fires in that cycle.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unsupported op in DECODE goes to ERROR. ERROR holds all enables at 0 and illegal=1, and stays there until rst.
- Undefined: an unsupported op returns to FETCH; illegal is constant 0 and the ERROR state is unreachable.

Test Plan:
- Reset: rst=1 for 2 cycles -> all enables 0 while asserted; state=0 after the first edge; FETCH outputs (ir_write=1, pc_write=1, alu_src_b=10) once rst=0.
- lw, op=0000011: state sequence 0,1,2,3,4; imm_src=000; reg_write=1 only in state 4; result_src=01 in state 4.
- sw, op=0100011: sequence 0,1,2,5; imm_src=001; mem_write=1 only in state 5; adr_src=1 in state 5.
- R sub, op=0110011, funct3=000, funct7b5=1: alu_control=001 in state 6; then 7 with reg_write=1. Same fields with op=0010011: alu_control=000 in state 8.
- beq/bne, op=1100011:
  - funct3=000, zero=1 -> pc_write=1 in state 10.
  - funct3=000, zero=0 -> pc_write=0.
  - funct3=001, zero=0 -> pc_write=1.
  - imm_src=010 in all cases.
- jal, op=1101111: sequence 0,1,9,7; imm_src=011; pc_write=1 in state 9. op=1111111: returns to state 0 (feature off); reaches state 12 with illegal=1 (ILLEGAL_TRAP_EN on).

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore main-control FSM for the multi-cycle RV32I core. Decodes the
//   instruction-register fields and drives imm_src for the immediate
//   extender, plus every datapath mux select and write enable.
//
//   Ports:
//     clk, rst                 rising-edge clock, synchronous active-high reset
//     op, funct3, funct7b5     instruction fields (instr[6:0], [14:12], [30])
//     zero                     ALU zero flag (branch resolution)
//     pc_write, ir_write,
//     mem_write, reg_write     write enables (forced 0 while rst=1)
//     adr_src, result_src,
//     alu_src_a, alu_src_b     datapath mux selects
//     alu_control              ALU operation
//     imm_src                  immediate format for the extender
//     state                    debug copy of the state register
//     illegal                  high in the ERROR state
//
//   Build option:
//     ILLEGAL_TRAP_EN  when defined, an unsupported opcode in DECODE parks the
//                      FSM in ERROR (illegal=1) until reset. When undefined,
//                      it returns to FETCH and illegal is tied 0.

module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [2:0]         imm_src,
    output logic [STATE_W-1:0] state,
    output logic               illegal
);

    localparam logic [STATE_W-1:0] FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] EXECUTER = STATE_W'(6);
    localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(7);
    localparam logic [STATE_W-1:0] EXECUTEI = STATE_W'(8);
    localparam logic [STATE_W-1:0] JAL      = STATE_W'(9);
    localparam logic [STATE_W-1:0] BRANCH   = STATE_W'(10);
    localparam logic [STATE_W-1:0] LUI      = STATE_W'(11);
`ifdef ILLEGAL_TRAP_EN
    localparam logic [STATE_W-1:0] ERROR    = STATE_W'(12);
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    // funct3 -> ALU op; allow_sub distinguishes R-type sub from I-type addi.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       allow_sub);
        logic [2:0] r;
        case (f3)
            3'b000:  r = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  r = ALU_AND;
            3'b110:  r = ALU_OR;
            3'b100:  r = ALU_XOR;
            3'b010:  r = ALU_SLT;
            3'b001:  r = ALU_SLL;
            3'b101:  r = ALU_SRL;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = ALUWB;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_d = ERROR;
`else
                    default:           state_d = FETCH;
`endif
                endcase
            end
            MEMADR:   state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            LUI:      state_d = ALUWB;
`ifdef ILLEGAL_TRAP_EN
            ERROR:    state_d = ERROR;
`endif
            default:  state_d = FETCH;
        endcase
    end

    // imm_src follows op in every state so the extender output is ready
    // by the time DECODE computes the branch/jal/auipc target.
    always_comb begin
        case (op)
            OP_STORE:          imm_src = 3'b001;
            OP_BRANCH:         imm_src = 3'b010;
            OP_JAL:            imm_src = 3'b011;
            OP_LUI, OP_AUIPC:  imm_src = 3'b100;
            default:           imm_src = 3'b000;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_control = alu_decode(funct3, funct7b5, 1'b1);
            end
            EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_decode(funct3, funct7b5, 1'b0);
            end
            ALUWB:    reg_write = 1'b1;
            // alu_out still holds the DECODE target; ALU makes old_pc+4 as link.
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                case (funct3)
                    3'b000:  pc_write = zero;
                    3'b001:  pc_write = ~zero;
                    default: pc_write = 1'b0;
                endcase
            end
            default: ;
        endcase
        // Reset aborts any in-flight instruction without side effects.
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_q == ERROR);
`else
    assign illegal = 1'b0;
`endif

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;
    logic [3:0] state;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .state(state),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] rs, a, b;
        logic [2:0] alu, imm;
        logic       ill;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] cur_imm;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic pcw, input logic adr,
                        input logic memw, input logic irw, input logic regw,
                        input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                        input logic [2:0] alu, input logic ill = 1'b0);
        exp_t e;
        e = '{st: st, pcw: pcw, adr: adr, memw: memw, irw: irw, regw: regw,
              rs: rs, a: a, b: b, alu: alu, imm: cur_imm, ill: ill};
        sb.push_back(e);
    endtask

    // Called at a negedge; checks one scoreboard entry per cycle.
    task automatic drain();
        exp_t  e;
        string s;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            #1;
            s = $sformatf("st%0d", e.st);
            check({s, " state"},       32'(state),       32'(e.st));
            check({s, " pc_write"},    32'(pc_write),    32'(e.pcw));
            check({s, " adr_src"},     32'(adr_src),     32'(e.adr));
            check({s, " mem_write"},   32'(mem_write),   32'(e.memw));
            check({s, " ir_write"},    32'(ir_write),    32'(e.irw));
            check({s, " reg_write"},   32'(reg_write),   32'(e.regw));
            check({s, " result_src"},  32'(result_src),  32'(e.rs));
            check({s, " alu_src_a"},   32'(alu_src_a),   32'(e.a));
            check({s, " alu_src_b"},   32'(alu_src_b),   32'(e.b));
            check({s, " alu_control"}, 32'(alu_control), 32'(e.alu));
            check({s, " imm_src"},     32'(imm_src),     32'(e.imm));
            check({s, " illegal"},     32'(illegal),     32'(e.ill));
            @(negedge clk);
        end
    endtask

    // Drive the instruction fields and queue the common FETCH/DECODE cycles.
    task automatic start(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input logic [2:0] imm);
        op = o; funct3 = f3; funct7b5 = f7; zero = z; cur_imm = imm;
        push(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000);
        push(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000);
    endtask

    initial begin
        rst = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        cur_imm = 3'b000;
        @(posedge clk); @(negedge clk);
        // Two reset cycles: FETCH selects, every enable held low.
        push(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000);
        push(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000);
        drain();
        rst = 1'b0;

        // lw: 0,1,2,3,4
        start(7'b0000011, 3'b010, 0, 0, 3'b000);
        push(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000);
        push(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000);
        push(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000);
        drain();

        // sw: 0,1,2,5
        start(7'b0100011, 3'b010, 0, 0, 3'b001);
        push(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000);
        push(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000);
        drain();

        // R-type sub / srl
        start(7'b0110011, 3'b000, 1, 0, 3'b000);
        push(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001);
        push(4'd7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000);
        drain();
        start(7'b0110011, 3'b101, 0, 0, 3'b000);
        push(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b111);
        push(4'd7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000);
        drain();

        // I-type: funct7b5 ignored for add; slt; and
        start(7'b0010011, 3'b000, 1, 0, 3'b000);
        push(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000);
        push(4'd7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000);
        drain();
        start(7'b0010011, 3'b010, 0, 0, 3'b000);
        push(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101);
        push(4'd7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000);
        drain();
        start(7'b0010011, 3'b111, 0, 0, 3'b000);
        push(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010);
        push(4'd7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000);
        drain();

        // Branches: beq taken/not, bne taken/not, unsupported funct3
        start(7'b1100011, 3'b000, 0, 1, 3'b010);
        push(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001);
        drain();
        start(7'b1100011, 3'b000, 0, 0, 3'b010);
        push(4'd10, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001);
        drain();
        start(7'b1100011, 3'b001, 0, 0, 3'b010);
        push(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001);
        drain();
        start(7'b1100011, 3'b001, 0, 1, 3'b010);
        push(4'd10, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001);
        drain();
        start(7'b1100011, 3'b100, 0, 1, 3'b010);
        push(4'd10, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001);
        drain();

        // jal: 0,1,9,7
        start(7'b1101111, 3'b000, 0, 0, 3'b011);
        push(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000);
        push(4'd7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000);
        drain();

        // lui: 0,1,11,7
        start(7'b0110111, 3'b000, 0, 0, 3'b100);
        push(4'd11, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b000);
        push(4'd7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000);
        drain();

        // auipc: 0,1,7
        start(7'b0010111, 3'b000, 0, 0, 3'b100);
        push(4'd7, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000);
        drain();

        // Reset mid-lw: MEMWB cycle with rst=1 must not write, then FETCH.
        start(7'b0000011, 3'b010, 0, 0, 3'b000);
        push(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000);
        push(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000);
        drain();
        rst = 1'b1;
        push(4'd4, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000);
        push(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000);
        drain();
        rst = 1'b0;

        // Unsupported opcode
        start(7'b1111111, 3'b000, 0, 0, 3'b000);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++)
            push(4'd12, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1);
        drain();
        rst = 1'b1;
        push(4'd12, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1);
        drain();
        rst = 1'b0;
`else
        drain();
`endif
        // Whichever build: back in FETCH afterwards, sw proceeds normally.
        start(7'b0100011, 3'b010, 0, 0, 3'b001);
        push(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000);
        push(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
